// File: rtl/neuron_weight_loader_pkg.sv
// Shared types for the neuron weight loader: FSM state encoding and the default weight word.
package neuron_weight_loader_pkg;

    localparam int WEIGHT_W = 16;

    typedef logic [WEIGHT_W-1:0] weight_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_BURST,
        S_RUN,
        S_CHECK,
        S_ERR
    } state_t;

endpackage

// File: rtl/neuron_weight_loader_weight_buffer.sv
// One-neuron staging RAM: one write port and one registered read port.
module weight_buffer
    import neuron_weight_loader_pkg::*;
#(
    parameter int DEPTH = 120,
    parameter int WIDTH = WEIGHT_W,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and read register have no reset so this maps onto block RAM;
    // every location is written during FILL before BURST reads it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/neuron_weight_loader.sv
// Weight-load transmitter: buffers one neuron's weights, bursts them gap-free, then enters inference.
// Optional checksum word per neuron with macro WLOAD_CHECKSUM_EN (adds CHECK/ERR states and wload_err).
module neuron_weight_loader
    import neuron_weight_loader_pkg::*;
#(
    parameter int NUM_NEURONS  = 4,
    parameter int IN_WIDTH     = 120,
    parameter int WEIGHT_WIDTH = WEIGHT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic                    w_in_valid,
    input  logic [WEIGHT_WIDTH-1:0] w_in_data,
    output logic                    w_in_ready,
    output logic [WEIGHT_WIDTH-1:0] weight,
    output logic                    startup,
    output logic [NUM_NEURONS-1:0]  neuron_en,
    output logic                    busy,
    output logic                    load_done,
    output logic                    run
`ifdef WLOAD_CHECKSUM_EN
    ,
    output logic                    wload_err
`endif
);

`ifdef WLOAD_CHECKSUM_EN
    localparam int FILL_LEN = IN_WIDTH + 1;
`else
    localparam int FILL_LEN = IN_WIDTH;
`endif
    localparam int AW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int CW = $clog2(FILL_LEN);
    localparam int BW = $clog2(IN_WIDTH + 2);
    localparam int KW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [BW-1:0]           bcnt;
    logic [KW-1:0]           k;
    logic                    transfer;
    logic                    fill_last;
    logic                    wr_en;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;
    logic [WEIGHT_WIDTH-1:0] rd_data;
`ifdef WLOAD_CHECKSUM_EN
    logic [WEIGHT_WIDTH-1:0] sum;
    logic [WEIGHT_WIDTH-1:0] chk;
`endif

    assign transfer  = (state == S_FILL) && w_in_valid && w_in_ready;
    assign fill_last = (cnt == CW'(FILL_LEN - 1));
`ifdef WLOAD_CHECKSUM_EN
    assign wr_en     = transfer && !fill_last;
`else
    assign wr_en     = transfer;
`endif

    // Burst cycle 0 only issues the first read; cycles 1..IN_WIDTH present words, the last one closes.
    assign rd_en   = (state == S_BURST) && (bcnt < BW'(IN_WIDTH));
    assign rd_addr = bcnt[AW-1:0];

    weight_buffer #(
        .DEPTH (IN_WIDTH),
        .WIDTH (WEIGHT_WIDTH),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (cnt[AW-1:0]),
        .wr_data (w_in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // NOTE: all state and output registers use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bcnt       <= '0;
            k          <= '0;
            w_in_ready <= 1'b0;
            weight     <= '0;
            startup    <= 1'b0;
            neuron_en  <= '0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            run        <= 1'b0;
`ifdef WLOAD_CHECKSUM_EN
            sum        <= '0;
            chk        <= '0;
            wload_err  <= 1'b0;
`endif
        end else begin
            load_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state      <= S_FILL;
                        k          <= '0;
                        cnt        <= '0;
                        w_in_ready <= 1'b1;
                        busy       <= 1'b1;
`ifdef WLOAD_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end

                S_FILL: begin
                    // Re-asserting here also ends the one idle cycle after a reload from RUN.
                    w_in_ready <= 1'b1;
                    busy       <= 1'b1;
                    if (transfer) begin
                        if (fill_last) begin
                            cnt        <= '0;
                            bcnt       <= '0;
                            w_in_ready <= 1'b0;
`ifdef WLOAD_CHECKSUM_EN
                            chk        <= w_in_data;
                            state      <= S_CHECK;
`else
                            state      <= S_BURST;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
`ifdef WLOAD_CHECKSUM_EN
                            sum <= sum + w_in_data;
`endif
                        end
                    end
                end

`ifdef WLOAD_CHECKSUM_EN
                S_CHECK: begin
                    if (sum == chk) begin
                        state <= S_BURST;
                    end else begin
                        state     <= S_ERR;
                        busy      <= 1'b0;
                        wload_err <= 1'b1;
                    end
                end

                S_ERR: begin
                    if (load_start) begin
                        state      <= S_FILL;
                        k          <= '0;
                        cnt        <= '0;
                        sum        <= '0;
                        wload_err  <= 1'b0;
                        w_in_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
`endif

                S_BURST: begin
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == BW'(IN_WIDTH + 1)) begin
                        bcnt      <= '0;
                        weight    <= '0;
                        startup   <= 1'b0;
                        neuron_en <= '0;
                        if (k == KW'(NUM_NEURONS - 1)) begin
                            state     <= S_RUN;
                            busy      <= 1'b0;
                            run       <= 1'b1;
                            load_done <= 1'b1;
                            neuron_en <= '1;
                        end else begin
                            state      <= S_FILL;
                            k          <= k + 1'b1;
                            w_in_ready <= 1'b1;
`ifdef WLOAD_CHECKSUM_EN
                            sum        <= '0;
`endif
                        end
                    end else if (bcnt != '0) begin
                        weight    <= rd_data;
                        startup   <= 1'b1;
                        neuron_en <= NUM_NEURONS'(1) << k;
                    end
                end

                S_RUN: begin
                    if (load_start) begin
                        state      <= S_FILL;
                        k          <= '0;
                        cnt        <= '0;
                        run        <= 1'b0;
                        neuron_en  <= '0;
                        w_in_ready <= 1'b0;
                        busy       <= 1'b0;
`ifdef WLOAD_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_weight_loader.sv
// Directed bench for neuron_weight_loader with NUM_NEURONS=2, IN_WIDTH=4 (also builds with WLOAD_CHECKSUM_EN).
module tb_neuron_weight_loader;
    import neuron_weight_loader_pkg::*;

    localparam int NN = 2;
    localparam int IW = 4;
    localparam int WW = WEIGHT_W;
`ifdef WLOAD_CHECKSUM_EN
    localparam int EXP_FIRST = 9;
    localparam int EXP_GAP   = 8;
`else
    localparam int EXP_FIRST = 7;
    localparam int EXP_GAP   = 6;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic          w_in_valid;
    logic [WW-1:0] w_in_data;
    logic          w_in_ready;
    logic [WW-1:0] weight;
    logic          startup;
    logic [NN-1:0] neuron_en;
    logic          busy;
    logic          load_done;
    logic          run;
`ifdef WLOAD_CHECKSUM_EN
    logic          wload_err;
`endif

    neuron_weight_loader #(
        .NUM_NEURONS  (NN),
        .IN_WIDTH     (IW),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .w_in_valid (w_in_valid),
        .w_in_data  (w_in_data),
        .w_in_ready (w_in_ready),
        .weight     (weight),
        .startup    (startup),
        .neuron_en  (neuron_en),
        .busy       (busy),
        .load_done  (load_done),
        .run        (run)
`ifdef WLOAD_CHECKSUM_EN
        ,
        .wload_err  (wload_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    weight_t       feed[$];
    weight_t       exp_w[$];
    weight_t       obs_w[$];
    int            seg_len[$];
    logic [NN-1:0] seg_en[$];
    int            gaps[$];
    int            first_en_c;
    int            ready_bad;
    int            ld_cnt;
    bit            got_stop;

    // Two neurons of four consecutive words starting at base+1, plus a checksum word when enabled.
    function automatic void fill_seq(input weight_t base);
        feed.delete();
        exp_w.delete();
        for (int n = 0; n < NN; n++) begin
`ifdef WLOAD_CHECKSUM_EN
            weight_t s;
            s = '0;
`endif
            for (int i = 0; i < IW; i++) begin
                weight_t w;
                w = base + WW'(n * IW + i + 1);
                feed.push_back(w);
                exp_w.push_back(w);
`ifdef WLOAD_CHECKSUM_EN
                s = s + w;
`endif
            end
`ifdef WLOAD_CHECKSUM_EN
            feed.push_back(s);
`endif
        end
    endfunction

    // Feeds `feed` and records what the neurons see. Entered and left on a falling edge.
    // stop_mode 0: first RUN cycle; 1: 2nd cycle of neuron 1's burst; 2: wload_err seen.
    task automatic drive_load(input bit do_start, input bit stall, input logic [63:0] ls_mask,
                              input int stop_mode);
        int            idx;
        int            cur_len;
        logic [NN-1:0] cur_en;
        bit            consumed;
        bit            saw_burst;
        obs_w.delete();
        seg_len.delete();
        seg_en.delete();
        gaps.delete();
        first_en_c = -1;
        ready_bad  = 0;
        ld_cnt     = 0;
        got_stop   = 1'b0;
        idx        = 0;
        cur_len    = 0;
        cur_en     = '0;
        consumed   = 1'b0;
        saw_burst  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) begin
                if (consumed) idx++;
                if (w_in_ready && (startup || run || neuron_en != '0)) ready_bad++;
                if (load_done) ld_cnt++;
                if (startup && neuron_en != '0) begin
                    obs_w.push_back(weight);
                    if (first_en_c < 0) first_en_c = c;
                end
                if (neuron_en != cur_en) begin
                    if (cur_en != '0) begin
                        seg_len.push_back(cur_len);
                        seg_en.push_back(cur_en);
                        saw_burst = 1'b1;
                    end else if (saw_burst) begin
                        gaps.push_back(cur_len);
                    end
                    cur_en  = neuron_en;
                    cur_len = 1;
                end else begin
                    cur_len++;
                end
                if (stop_mode == 0 && run) got_stop = 1'b1;
                if (stop_mode == 1 && neuron_en == 2'b10 && cur_len == 2) got_stop = 1'b1;
`ifdef WLOAD_CHECKSUM_EN
                if (stop_mode == 2 && wload_err) got_stop = 1'b1;
`endif
                if (got_stop) break;
            end
            load_start = (c == 0 && do_start) || ls_mask[c % 64];
            w_in_valid = (idx < feed.size()) && (!stall || c[0] == 1'b0);
            w_in_data  = (idx < feed.size()) ? feed[idx] : '0;
            consumed   = w_in_ready && w_in_valid;
            @(negedge clk);
        end
        load_start = 1'b0;
        w_in_valid = 1'b0;
        checks++;
        if (!got_stop) begin
            errors++;
            $display("FAIL load_timeout: stop condition %0d not reached within 300 cycles", stop_mode);
        end
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        load_start = 1'b0;
        w_in_valid = 1'b0;
        w_in_data  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({w_in_ready, startup, busy, load_done, run} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {w_in_ready, startup, busy, load_done, run});
        end
        checks++;
        if ({weight, neuron_en} !== '0) begin
            errors++;
            $display("FAIL reset_data: weight=%h en=%b expected 0", weight, neuron_en);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (w_in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: ready=%b busy=%b expected 0 0", w_in_ready, busy);
        end
    endtask

    task automatic test_basic_load;
        fill_seq(16'd0);
        drive_load(1'b1, 1'b0, 64'd0, 0);
        checks++;
        if (obs_w.size() != 8) begin
            errors++;
            $display("FAIL basic_count: got %0d words expected 8", obs_w.size());
        end
        for (int i = 0; i < obs_w.size() && i < 8; i++) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL basic_word%0d: got %h expected %h", i, obs_w[i], exp_w[i]);
            end
        end
        checks++;
        if (seg_len.size() != 2 || seg_len[0] != 4 || seg_len[1] != 4 || seg_en[0] !== 2'b01 || seg_en[1] !== 2'b10) begin
            errors++;
            $display("FAIL basic_segments: got %0d segments, first len %0d en %b", seg_len.size(),
                     (seg_len.size() > 0) ? seg_len[0] : -1, (seg_en.size() > 0) ? seg_en[0] : 2'bxx);
        end
        checks++;
        if (first_en_c != EXP_FIRST) begin
            errors++;
            $display("FAIL basic_latency: first burst cycle %0d expected %0d", first_en_c, EXP_FIRST);
        end
        checks++;
        if (gaps.size() != 1 || gaps[0] != EXP_GAP) begin
            errors++;
            $display("FAIL basic_gap: got %0d gaps, first %0d expected %0d", gaps.size(),
                     (gaps.size() > 0) ? gaps[0] : -1, EXP_GAP);
        end
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL basic_ready: ready outside FILL %0d times expected 0", ready_bad);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (load_done) ld_cnt++;
            checks++;
            if ({run, neuron_en, startup, busy, w_in_ready} !== 6'b1_11_0_0_0) begin
                errors++;
                $display("FAIL run_state%0d: run=%b en=%b startup=%b busy=%b ready=%b expected 1 11 0 0 0",
                         i, run, neuron_en, startup, busy, w_in_ready);
            end
        end
        checks++;
        if (ld_cnt != 1) begin
            errors++;
            $display("FAIL load_done_pulses: got %0d expected 1", ld_cnt);
        end
    endtask

    task automatic test_run_reload;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checks++;
        if ({run, neuron_en, busy, w_in_ready, startup, load_done} !== 7'b0) begin
            errors++;
            $display("FAIL reload_gap: run=%b en=%b busy=%b ready=%b expected all 0", run, neuron_en, busy, w_in_ready);
        end
        @(negedge clk);
        checks++;
        if (w_in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reload_fill: ready=%b busy=%b expected 1 1", w_in_ready, busy);
        end
        fill_seq(16'd20);
        drive_load(1'b0, 1'b0, 64'd0, 0);
        checks++;
        if (obs_w.size() != 8 || obs_w[0] !== 16'd21 || obs_w[7] !== 16'd28) begin
            errors++;
            $display("FAIL reload_words: got %0d words first %h expected 8 words 0015..001c", obs_w.size(),
                     (obs_w.size() > 0) ? obs_w[0] : 16'hxxxx);
        end
        checks++;
        if (seg_en.size() != 2 || seg_en[0] !== 2'b01) begin
            errors++;
            $display("FAIL reload_k0: got %0d segments expected neuron 0 first", seg_en.size());
        end
    endtask

    task automatic test_ignore_start;
        logic [63:0] mask;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mask = '0;
        mask[3] = 1'b1;
        mask[EXP_FIRST + 1] = 1'b1;
        fill_seq(16'd40);
        drive_load(1'b1, 1'b0, mask, 0);
        checks++;
        if (obs_w.size() != 8) begin
            errors++;
            $display("FAIL ignore_count: got %0d words expected 8", obs_w.size());
        end
        for (int i = 0; i < obs_w.size() && i < 8; i++) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL ignore_word%0d: got %h expected %h", i, obs_w[i], exp_w[i]);
            end
        end
        checks++;
        if (first_en_c != EXP_FIRST || seg_len.size() != 2 || ld_cnt != 1) begin
            errors++;
            $display("FAIL ignore_timing: first %0d segs %0d done %0d expected %0d 2 1",
                     first_en_c, seg_len.size(), ld_cnt, EXP_FIRST);
        end
    endtask

    task automatic test_stall;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fill_seq(16'd60);
        drive_load(1'b1, 1'b1, 64'd0, 0);
        checks++;
        if (obs_w.size() != 8) begin
            errors++;
            $display("FAIL stall_count: got %0d words expected 8", obs_w.size());
        end
        for (int i = 0; i < obs_w.size() && i < 8; i++) begin
            checks++;
            if (obs_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL stall_word%0d: got %h expected %h", i, obs_w[i], exp_w[i]);
            end
        end
        checks++;
        if (seg_len.size() != 2 || seg_len[0] != 4 || seg_len[1] != 4) begin
            errors++;
            $display("FAIL stall_contiguous: got %0d segments expected two of length 4", seg_len.size());
        end
        checks++;
        if (gaps.size() != 1 || gaps[0] < IW) begin
            errors++;
            $display("FAIL stall_gap: got %0d gaps, first %0d expected >= %0d", gaps.size(),
                     (gaps.size() > 0) ? gaps[0] : -1, IW);
        end
        checks++;
        if (ready_bad != 0 || ld_cnt != 1) begin
            errors++;
            $display("FAIL stall_ctrl: ready outside FILL %0d, load_done %0d expected 0 1", ready_bad, ld_cnt);
        end
    endtask

    task automatic test_reset_mid_burst;
        fill_seq(16'd80);
        drive_load(1'b1, 1'b0, 64'd0, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({weight, startup, neuron_en, w_in_ready, busy, load_done, run} !== '0) begin
            errors++;
            $display("FAIL midburst_reset: weight=%h startup=%b en=%b ready=%b busy=%b done=%b run=%b expected all 0",
                     weight, startup, neuron_en, w_in_ready, busy, load_done, run);
        end
        fill_seq(16'd100);
        drive_load(1'b1, 1'b0, 64'd0, 0);
        checks++;
        if (obs_w.size() != 8 || obs_w[0] !== 16'd101 || seg_en[0] !== 2'b01) begin
            errors++;
            $display("FAIL midburst_reload: got %0d words first %h expected 8 words first 0065 on neuron 0",
                     obs_w.size(), (obs_w.size() > 0) ? obs_w[0] : 16'hxxxx);
        end
        checks++;
        if (obs_w.size() != 8 || obs_w[4] !== 16'd105) begin
            errors++;
            $display("FAIL midburst_neuron1: got %h expected 0069", (obs_w.size() > 4) ? obs_w[4] : 16'hxxxx);
        end
    endtask

`ifdef WLOAD_CHECKSUM_EN
    task automatic test_checksum;
        feed = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd11};
        drive_load(1'b1, 1'b0, 64'd0, 2);
        checks++;
        if (obs_w.size() != 0 || {neuron_en, startup, busy, w_in_ready, run} !== 6'b0) begin
            errors++;
            $display("FAIL chk_bad_burst: %0d words, en=%b busy=%b expected none", obs_w.size(), neuron_en, busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wload_err !== 1'b1 || neuron_en !== 2'b00) begin
            errors++;
            $display("FAIL chk_sticky: err=%b en=%b expected 1 00", wload_err, neuron_en);
        end
        feed = '{16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'hfffc,
                 16'd1, 16'd2, 16'd3, 16'd4, 16'd10};
        exp_w = '{16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'd1, 16'd2, 16'd3, 16'd4};
        drive_load(1'b1, 1'b0, 64'd0, 0);
        checks++;
        if (wload_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_clear: err=%b expected 0", wload_err);
        end
        checks++;
        if (obs_w.size() != 8 || obs_w[0] !== 16'hffff || obs_w[4] !== 16'd1 || obs_w[7] !== 16'd4) begin
            errors++;
            $display("FAIL chk_wrap: got %0d words expected ffff x4 then 1..4", obs_w.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_run_reload();
        test_ignore_start();
        test_stall();
        test_reset_mid_burst();
`ifdef WLOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
